// File: rtl/mem_stage_pkg.sv
// Encodings shared by the MEM stage buffer, its load aligner and its interface users.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4,
    LD_LWL = 3'd5,
    LD_LWR = 3'd6
  } ld_op_e;

  typedef enum logic [1:0] {
    WSRC_ALU  = 2'b00,
    WSRC_LOAD = 2'b01,
    WSRC_LINK = 2'b10
  } wsrc_e;

endpackage

// File: rtl/mem_stage_buf_if.sv
// EXE-side, data-response, flush and WB-side signals of the MEM stage buffer.
interface mem_stage_buf_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          exe_valid;
    logic          exe_ready;
    logic [31:0]   exe_pc;
    logic          exe_wen;
    logic [RW-1:0] exe_wreg;
    logic [1:0]    exe_wsrc;
    logic [2:0]    exe_ld_op;
    logic [DW-1:0] exe_alu;
    logic [DW-1:0] exe_link;
    logic [DW-1:0] exe_rt;
    logic          dresp_valid;
    logic [DW-1:0] dresp_rdata;
    logic          flush;
    logic          wb_valid;
    logic          wb_ready;
    logic [31:0]   wb_pc;
    logic          wb_wen;
    logic [RW-1:0] wb_wreg;
    logic [DW-1:0] wb_wdata;
    logic          busy;

    modport master (
        output exe_valid, exe_pc, exe_wen, exe_wreg, exe_wsrc, exe_ld_op,
               exe_alu, exe_link, exe_rt, dresp_valid, dresp_rdata, flush, wb_ready,
        input  exe_ready, wb_valid, wb_pc, wb_wen, wb_wreg, wb_wdata, busy
    );

    modport slave (
        input  exe_valid, exe_pc, exe_wen, exe_wreg, exe_wsrc, exe_ld_op,
               exe_alu, exe_link, exe_rt, dresp_valid, dresp_rdata, flush, wb_ready,
        output exe_ready, wb_valid, wb_pc, wb_wen, wb_wreg, wb_wdata, busy
    );
endinterface

// File: rtl/mem_stage_buf_load_align.sv
// Combinational load data alignment: sub-word extract/extend and LWL/LWR merge with old rt.
module load_align
    import mem_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    ld_op,
    input  logic [1:0]    off,
    input  logic [DW-1:0] rdata,
    input  logic [DW-1:0] rt,
    output logic [DW-1:0] wdata
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b     = 8'(rdata >> {off, 3'b000});
        h     = 16'(rdata >> {off[1], 4'b0000});
        wdata = '0;
        case (ld_op)
            LD_LW:  wdata = rdata;
            LD_LB:  wdata = {{(DW-8){b[7]}}, b};
            LD_LBU: wdata = {{(DW-8){1'b0}}, b};
            LD_LH:  wdata = off[0] ? '0 : {{(DW-16){h[15]}}, h};
            LD_LHU: wdata = off[0] ? '0 : {{(DW-16){1'b0}}, h};
            // LWL fills from the top down, LWR from the bottom up
            LD_LWL: begin
                case (off)
                    2'd0: wdata = {rdata[7:0],  rt[DW-9:0]};
                    2'd1: wdata = {rdata[15:0], rt[DW-17:0]};
                    2'd2: wdata = {rdata[23:0], rt[DW-25:0]};
                    default: wdata = rdata;
                endcase
            end
            LD_LWR: begin
                case (off)
                    2'd0: wdata = rdata;
                    2'd1: wdata = {rt[DW-1:DW-8],  rdata[DW-1:8]};
                    2'd2: wdata = {rt[DW-1:DW-16], rdata[DW-1:16]};
                    default: wdata = {rt[DW-1:DW-24], rdata[DW-1:24]};
                endcase
            end
            default: wdata = '0;
        endcase
    end
endmodule

// File: rtl/mem_stage_buf.sv
// In-order MEM stage buffer: matches in-order SRAM responses to pending loads, aligns the
// head for WB, and counts responses still owed to flushed loads so they can be dropped.
module mem_stage_buf
    import mem_stage_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int RW    = 5
) (
    input logic            clk,
    input logic            resetn,
    mem_stage_buf_if.slave bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int DRW = $clog2(2 * DEPTH + 1);

    logic [31:0]   pc_q   [DEPTH];
    logic          wen_q  [DEPTH];
    logic [RW-1:0] wreg_q [DEPTH];
    logic [1:0]    wsrc_q [DEPTH];
    logic [2:0]    op_q   [DEPTH];
    logic [DW-1:0] alu_q  [DEPTH];
    logic [DW-1:0] link_q [DEPTH];
    logic [DW-1:0] rt_q   [DEPTH];
    logic [DW-1:0] rd_q   [DEPTH];

    logic [DEPTH-1:0] need_q;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q;
    logic [DRW-1:0]   drop_q;

    logic [PW-1:0]    slot [DEPTH];
    logic [DEPTH-1:0] live, need_left;
    logic             hit;
    logic [PW-1:0]    hit_idx;
    logic             resp_drop, resp_hit;
    logic [DRW-1:0]   flushed_loads;
    logic             eligible, accept, retire;
    logic [DW-1:0]    load_data, head_data;

    // Scan from head so the oldest waiting load takes the response
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        live    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot[k]       = head_q + PW'(k);
            live[slot[k]] = CW'(k) < count_q;
            if (!hit && live[slot[k]] && need_q[slot[k]]) begin
                hit     = 1'b1;
                hit_idx = slot[k];
            end
        end
    end

    assign resp_drop = bus.dresp_valid & (drop_q != '0);
    assign resp_hit  = bus.dresp_valid & ~resp_drop & hit;

    always_comb begin
        need_left = need_q & live;
        if (resp_hit) need_left[hit_idx] = 1'b0;
        flushed_loads = '0;
        for (int i = 0; i < DEPTH; i++) flushed_loads = flushed_loads + DRW'(need_left[i]);
    end

    assign eligible      = (count_q != '0) & ~need_q[head_q];
    assign bus.wb_valid  = eligible & ~bus.flush;
    assign bus.exe_ready = resetn & (count_q < CW'(DEPTH)) & ~bus.flush & (drop_q < DRW'(DEPTH));
    assign accept        = bus.exe_valid & bus.exe_ready;
    assign retire        = bus.wb_valid & bus.wb_ready;
    assign bus.busy      = (count_q != '0) | (drop_q != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            need_q  <= '0;
        end else if (bus.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            need_q  <= '0;
            drop_q  <= drop_q - DRW'(resp_drop) + flushed_loads;
        end else begin
            if (resp_hit) need_q[hit_idx] <= 1'b0;
            if (accept) begin
                need_q[tail_q] <= (bus.exe_wsrc == WSRC_LOAD);
                tail_q         <= tail_q + 1'b1;
            end
            if (retire) head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(accept) - CW'(retire);
            drop_q  <= drop_q - DRW'(resp_drop);
        end
    end

    // Payload needs no reset; it is only observed once its entry is live
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_q[tail_q]   <= bus.exe_pc;
            wen_q[tail_q]  <= bus.exe_wen;
            wreg_q[tail_q] <= bus.exe_wreg;
            wsrc_q[tail_q] <= bus.exe_wsrc;
            op_q[tail_q]   <= bus.exe_ld_op;
            alu_q[tail_q]  <= bus.exe_alu;
            link_q[tail_q] <= bus.exe_link;
            rt_q[tail_q]   <= bus.exe_rt;
        end
        if (resp_hit) rd_q[hit_idx] <= bus.dresp_rdata;
    end

    load_align #(.DW(DW)) u_align (
        .ld_op (op_q[head_q]),
        .off   (alu_q[head_q][1:0]),
        .rdata (rd_q[head_q]),
        .rt    (rt_q[head_q]),
        .wdata (load_data)
    );

    always_comb begin
        head_data = '0;
        case (wsrc_q[head_q])
            WSRC_ALU:  head_data = alu_q[head_q];
            WSRC_LOAD: head_data = load_data;
            WSRC_LINK: head_data = link_q[head_q];
            default:   head_data = '0;
        endcase
    end

    assign bus.wb_pc    = eligible ? pc_q[head_q]   : '0;
    assign bus.wb_wen   = eligible ? wen_q[head_q]  : 1'b0;
    assign bus.wb_wreg  = eligible ? wreg_q[head_q] : '0;
    assign bus.wb_wdata = eligible ? head_data      : '0;
endmodule

// File: tb/tb_mem_stage_buf.sv
// Bench for mem_stage_buf: directed scenarios then random traffic against a queue-based model.
module tb_mem_stage_buf;
    localparam int DW = 32, RW = 5, DEPTH = 2;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    mem_stage_buf_if #(.DW(DW), .RW(RW)) bus ();
    mem_stage_buf #(.DW(DW), .DEPTH(DEPTH), .RW(RW)) dut (
        .clk(clk), .resetn(resetn), .bus(bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  wreg;
        logic [1:0]  wsrc;
        logic [2:0]  op;
        logic [31:0] alu, link, rt, rd;
        bit          have;
    } ent_t;

    ent_t        q[$];
    int          drop_m = 0;
    int          vecs = 0, errs = 0, n_ret = 0;
    bit          ret_seen;
    logic [31:0] ret_data;

    function automatic logic [31:0] ref_align(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] rd, input logic [31:0] rt);
        int sh;
        logic [31:0] v;
        logic [63:0] m;
        sh = 8 * int'(off);
        case (op)
            3'd0: return rd;
            3'd1, 3'd2: begin
                v = (rd >> sh) & 32'hFF;
                if (op == 3'd1 && v[7]) v = v | 32'hFFFFFF00;
                return v;
            end
            3'd3, 3'd4: begin
                if (off[0]) return 32'h0;
                v = (rd >> sh) & 32'hFFFF;
                if (op == 3'd3 && v[15]) v = v | 32'hFFFF0000;
                return v;
            end
            3'd5: begin
                m = (64'd1 << (24 - sh)) - 64'd1;
                return (rd << (24 - sh)) | (rt & m[31:0]);
            end
            3'd6: return (rd >> sh) | (rt & ~(32'hFFFFFFFF >> sh));
            default: return 32'h0;
        endcase
    endfunction

    function automatic int outstanding();
        int n = drop_m;
        foreach (q[i]) if (q[i].wsrc == 2'b01 && !q[i].have) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, then advance one clock and update the model
    task automatic tick();
        bit er, ev, acc, ret;
        logic [31:0] ew;
        ent_t e;
        #1;
        er = (q.size() < DEPTH) && !bus.flush && (drop_m < DEPTH);
        ev = (q.size() > 0) && (q[0].wsrc != 2'b01 || q[0].have) && !bus.flush;
        chk("exe_ready", 32'(bus.exe_ready), 32'(er));
        chk("wb_valid", 32'(bus.wb_valid), 32'(ev));
        chk("busy", 32'(bus.busy), 32'(q.size() > 0 || drop_m > 0));
        if (ev) begin
            ew = q[0].wsrc == 2'b00 ? q[0].alu :
                 q[0].wsrc == 2'b10 ? q[0].link :
                 q[0].wsrc == 2'b01 ? ref_align(q[0].op, q[0].alu[1:0], q[0].rd, q[0].rt) : 32'h0;
            chk("wb_pc", bus.wb_pc, q[0].pc);
            chk("wb_wen", 32'(bus.wb_wen), 32'(q[0].wen));
            chk("wb_wreg", 32'(bus.wb_wreg), 32'(q[0].wreg));
            chk("wb_wdata", bus.wb_wdata, ew);
        end
        acc = bus.exe_valid && er;
        ret = ev && bus.wb_ready;
        if (ret) begin
            ret_seen = 1'b1;
            ret_data = bus.wb_wdata;
            n_ret++;
        end
        @(posedge clk);
        if (bus.dresp_valid) begin
            if (drop_m > 0) drop_m--;
            else begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].wsrc == 2'b01 && !q[i].have) begin
                        q[i].rd   = bus.dresp_rdata;
                        q[i].have = 1'b1;
                        break;
                    end
                end
            end
        end
        if (bus.flush) begin
            foreach (q[i]) if (q[i].wsrc == 2'b01 && !q[i].have) drop_m++;
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (acc) begin
                e.pc = bus.exe_pc; e.wen = bus.exe_wen; e.wreg = bus.exe_wreg;
                e.wsrc = bus.exe_wsrc; e.op = bus.exe_ld_op; e.alu = bus.exe_alu;
                e.link = bus.exe_link; e.rt = bus.exe_rt; e.rd = 32'h0; e.have = 1'b0;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] wsrc, input logic [2:0] op,
                         input logic [31:0] alu, input logic [31:0] rt);
        bus.exe_valid = 1'b1;
        bus.exe_pc    = $urandom;
        bus.exe_wen   = 1'($urandom);
        bus.exe_wreg  = 5'($urandom);
        bus.exe_wsrc  = wsrc;
        bus.exe_ld_op = op;
        bus.exe_alu   = alu;
        bus.exe_link  = $urandom;
        bus.exe_rt    = rt;
    endtask

    task automatic issue(input logic [1:0] wsrc, input logic [2:0] op,
                         input logic [31:0] alu, input logic [31:0] rt);
        drive(wsrc, op, alu, rt);
        tick();
        bus.exe_valid = 1'b0;
    endtask

    task automatic resp(input logic [31:0] d);
        bus.dresp_valid = 1'b1;
        bus.dresp_rdata = d;
        tick();
        bus.dresp_valid = 1'b0;
    endtask

    task automatic wait_ret(input string tag, input logic [31:0] exp);
        ret_seen = 1'b0;
        for (int i = 0; i < 10 && !ret_seen; i++) tick();
        chk({tag, "_retired"}, 32'(ret_seen), 32'd1);
        if (ret_seen) chk(tag, ret_data, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_exe_ready"}, 32'(bus.exe_ready), 32'd0);
        chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_wb_pc"}, bus.wb_pc, 32'd0);
        chk({tag, "_wb_wen"}, 32'(bus.wb_wen), 32'd0);
        chk({tag, "_wb_wreg"}, 32'(bus.wb_wreg), 32'd0);
        chk({tag, "_wb_wdata"}, bus.wb_wdata, 32'd0);
    endtask

    initial begin
        int n0, r;
        bus.exe_valid = 1'b1; bus.exe_pc = '0; bus.exe_wen = 1'b0; bus.exe_wreg = '0;
        bus.exe_wsrc = '0; bus.exe_ld_op = '0; bus.exe_alu = '0; bus.exe_link = '0;
        bus.exe_rt = '0; bus.dresp_valid = 1'b0; bus.dresp_rdata = '0; bus.flush = 1'b0;
        bus.wb_ready = 1'b1;
        #1 resetn = 1'b0;
        #1 chk_all_zero("reset");
        bus.exe_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        issue(2'b01, 3'd1, 32'h1002, 32'h0);
        resp(32'h12845678);
        wait_ret("lb", 32'hFFFFFF84);
        issue(2'b01, 3'd2, 32'h2002, 32'h0);
        resp(32'h12845678);
        wait_ret("lbu", 32'h00000084);
        issue(2'b01, 3'd5, 32'h3001, 32'hAABBCCDD);
        resp(32'h11223344);
        wait_ret("lwl", 32'h3344CCDD);
        issue(2'b01, 3'd6, 32'h4002, 32'hAABBCCDD);
        resp(32'h11223344);
        wait_ret("lwr", 32'hAABB1122);

        issue(2'b01, 3'd0, 32'h100, 32'h0);
        issue(2'b01, 3'd0, 32'h104, 32'h0);
        #1 chk("full_ready", 32'(bus.exe_ready), 32'd0);
        resp(32'h1);
        wait_ret("full_first", 32'h1);
        #1 chk("ready_after", 32'(bus.exe_ready), 32'd1);
        resp(32'h2);
        wait_ret("full_second", 32'h2);

        issue(2'b01, 3'd0, 32'h200, 32'h0);
        issue(2'b01, 3'd0, 32'h204, 32'h0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        resp(32'hDEAD0001);
        resp(32'hDEAD0002);
        #1 chk("drop_drained", 32'(bus.busy), 32'd0);
        chk("flushed_no_wb", 32'(bus.wb_valid), 32'd0);
        issue(2'b01, 3'd0, 32'h300, 32'h0);
        resp(32'hCAFEF00D);
        wait_ret("after_flush", 32'hCAFEF00D);

        bus.wb_ready = 1'b0;
        issue(2'b00, 3'd0, 32'h5, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("hold_valid", 32'(bus.wb_valid), 32'd1);
            chk("hold_data", bus.wb_wdata, 32'h5);
            tick();
        end
        n0 = n_ret;
        bus.wb_ready = 1'b1;
        tick();
        tick();
        chk("single_retire", 32'(n_ret - n0), 32'd1);

        bus.wb_ready = 1'b0;
        issue(2'b00, 3'd0, 32'h7, 32'h0);
        issue(2'b10, 3'd0, 32'h8, 32'h0);
        drive(2'b00, 3'd0, 32'h9, 32'h0);
        #2 resetn = 1'b0;
        #1 chk_all_zero("mid_reset");
        q.delete();
        drop_m = 0;
        bus.exe_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        bus.wb_ready = 1'b1;
        tick();
        chk("post_reset_busy", 32'(bus.busy), 32'd0);

        for (int c = 0; c < 400; c++) begin
            bus.flush    = ($urandom_range(0, 19) == 0);
            bus.wb_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 3);
                drive(r == 3 ? 2'b01 : 2'(r), 3'($urandom_range(0, 7)), $urandom, $urandom);
            end else bus.exe_valid = 1'b0;
            bus.dresp_valid = (outstanding() > 0) && ($urandom_range(0, 2) == 0);
            bus.dresp_rdata = $urandom;
            tick();
        end
        bus.flush = 1'b0;
        bus.exe_valid = 1'b0;
        bus.wb_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.dresp_valid = (outstanding() > 0);
            bus.dresp_rdata = $urandom;
            tick();
        end
        bus.dresp_valid = 1'b0;
        #1 chk("drain_busy", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
